// File: rtl/alu_op_sched.sv
// alu_op_sched
//   Schedules operations from two requesters onto one shared 4-bit ALU. A
//   round-robin arbiter picks one request, the operands are held steady on the
//   ALU bus for the op's latency, and the formatted result is handed back
//   through a response handshake.
//
// Handshake rule (both request ports and the response port): a transfer
// happens on a rising clock edge where valid and ready are both high. Valid
// may drop before ready without effect. The response fields stay constant
// while rsp_valid is high and rsp_ready is low.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   reqN_valid/ready/op/x/y       request ports, N = 0, 1
//   alu_en/op/x/y/cin             registered command bus to the ALU
//   alu_result, alu_cout          ALU mux outputs
//   rsp_valid/ready/id/result/cout/err   response port
//   dbg_state                     current FSM state (IDLE=0 ISSUE=1 WAIT=2 RESP=3)
module alu_op_sched #(
  parameter int MULT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_op,
  input  logic [3:0] req0_x,
  input  logic [3:0] req0_y,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_op,
  input  logic [3:0] req1_x,
  input  logic [3:0] req1_y,
  output logic       alu_en,
  output logic [3:0] alu_op,
  output logic [3:0] alu_x,
  output logic [3:0] alu_y,
  output logic       alu_cin,
  input  logic [7:0] alu_result,
  input  logic       alu_cout,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_result,
  output logic       rsp_cout,
  output logic       rsp_err,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h8;
  localparam logic [3:0] OP_SUB  = 4'h9;
  localparam logic [3:0] OP_MULT = 4'hA;
  // Counter only needs to hold MULT_CYCLES-2.
  localparam int CNT_W = (MULT_CYCLES > 2) ? $clog2(MULT_CYCLES) : 1;

  state_t             r_state;
  state_t             w_next_state;
  logic               r_last;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_alu_op;
  logic [3:0]         r_alu_x;
  logic [3:0]         r_alu_y;
  logic               r_alu_cin;
  logic               r_rsp_id;
  logic [7:0]         r_rsp_result;
  logic               r_rsp_cout;
  logic               r_rsp_err;

  logic               w_any_valid;
  logic               w_gnt_id;
  logic [3:0]         w_sel_op;
  logic [3:0]         w_sel_x;
  logic [3:0]         w_sel_y;
  logic               w_legal;
  logic               w_is_mult;
  logic               w_accept;
  logic               w_capture;

  // Arbitration: on a tie the requester that did not win last time goes
  // next; a lone requester always wins.
  always_comb begin
    w_any_valid = req0_valid | req1_valid;
    w_gnt_id    = (req0_valid & req1_valid) ? ~r_last : req1_valid;
    w_sel_op    = w_gnt_id ? req1_op : req0_op;
    w_sel_x     = w_gnt_id ? req1_x  : req0_x;
    w_sel_y     = w_gnt_id ? req1_y  : req0_y;
    w_legal     = (w_sel_op <= OP_MULT);
    w_is_mult   = (r_alu_op == OP_MULT);
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    alu_en       = 1'b0;
    rsp_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // rst_n gating keeps ready low while reset is held with valid high.
        if (w_any_valid && rst_n) begin
          w_accept     = 1'b1;
          req0_ready   = ~w_gnt_id;
          req1_ready   = w_gnt_id;
          w_next_state = w_legal ? S_ISSUE : S_RESP;
        end
      end
      S_ISSUE: begin
        alu_en = 1'b1;
        if (!w_is_mult || (MULT_CYCLES == 1)) begin
          w_capture    = 1'b1;
          w_next_state = S_RESP;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        alu_en = 1'b1;
        if (r_cnt == '0) begin
          w_capture    = 1'b1;
          w_next_state = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last       <= 1'b1;
      r_cnt        <= '0;
      r_alu_op     <= 4'h0;
      r_alu_x      <= 4'h0;
      r_alu_y      <= 4'h0;
      r_alu_cin    <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= 8'h00;
      r_rsp_cout   <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_state <= w_next_state;

      if (w_accept) begin
        r_last    <= w_gnt_id;
        r_rsp_id  <= w_gnt_id;
        r_rsp_err <= ~w_legal;
        if (w_legal) begin
          r_alu_op  <= w_sel_op;
          r_alu_x   <= w_sel_x;
          r_alu_y   <= w_sel_y;
          r_alu_cin <= (w_sel_op == OP_SUB);
        end else begin
          // Illegal op: the ALU bus keeps its previous values and the
          // response is fully formed here.
          r_rsp_result <= 8'h00;
          r_rsp_cout   <= 1'b0;
        end
      end

      // Remaining WAIT cycles after the current one.
      if ((r_state == S_ISSUE) && (w_next_state == S_WAIT)) begin
        r_cnt <= CNT_W'(MULT_CYCLES - 2);
      end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (w_capture) begin
        r_rsp_result <= w_is_mult ? alu_result : {4'b0000, alu_result[3:0]};
        r_rsp_cout   <= ((r_alu_op == OP_ADD) || (r_alu_op == OP_SUB)) ? alu_cout : 1'b0;
      end
    end
  end

  assign alu_op     = r_alu_op;
  assign alu_x      = r_alu_x;
  assign alu_y      = r_alu_y;
  assign alu_cin    = r_alu_cin;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_cout   = r_rsp_cout;
  assign rsp_err    = r_rsp_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_alu_op_sched.sv
// Testbench for alu_op_sched: randomized and directed requests, a bench-side
// ALU model, a reference model feeding an expected queue, and a monitor that
// compares every response.
module tb_alu_op_sched;
  localparam int MC = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_op = 4'h0, req0_x = 4'h0, req0_y = 4'h0;
  logic [3:0] req1_op = 4'h0, req1_x = 4'h0, req1_y = 4'h0;
  logic       alu_en;
  logic [3:0] alu_op, alu_x, alu_y;
  logic       alu_cin;
  logic [7:0] alu_result;
  logic       alu_cout;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic       rsp_id;
  logic [7:0] rsp_result;
  logic       rsp_cout, rsp_err;
  logic [1:0] dbg_state;

  alu_op_sched #(.MULT_CYCLES(MC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_x(req1_x), .req1_y(req1_y),
    .alu_en(alu_en), .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_cout(rsp_cout), .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bench ALU ----------------
  // Upper nibble and carry carry junk where they are not meaningful; the
  // mult result only appears once the op has been held MC cycles.
  int en_run;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_run <= 0;
    else if (alu_en) en_run <= en_run + 1;
    else en_run <= 0;
  end

  logic [4:0] alu_sum;
  always_comb begin
    alu_sum    = 5'd0;
    alu_result = {~alu_x, 4'h0};
    alu_cout   = 1'b1;
    case (alu_op)
      4'h0: alu_result[3:0] = alu_x & alu_y;
      4'h1: alu_result[3:0] = ~(alu_x & alu_y);
      4'h2: alu_result[3:0] = alu_x | alu_y;
      4'h3: alu_result[3:0] = ~(alu_x | alu_y);
      4'h4: alu_result[3:0] = alu_x ^ alu_y;
      4'h5: alu_result[3:0] = ~(alu_x ^ alu_y);
      4'h6: alu_result[3:0] = ~alu_x;
      4'h7: alu_result[3:0] = {alu_x[2:0], 1'b0};
      4'h8: begin
        alu_sum = {1'b0, alu_x} + {1'b0, alu_y} + {4'b0000, alu_cin};
        alu_result[3:0] = alu_sum[3:0];
        alu_cout = alu_sum[4];
      end
      4'h9: begin
        alu_sum = {1'b0, alu_x} + {1'b0, ~alu_y} + {4'b0000, alu_cin};
        alu_result[3:0] = alu_sum[3:0];
        alu_cout = alu_sum[4];
      end
      4'hA: alu_result = (en_run >= MC - 1) ? ({4'b0000, alu_x} * {4'b0000, alu_y}) : 8'h5A;
      default: ;
    endcase
  end

  // ---------------- reference model / scoreboard ----------------
  typedef struct packed {
    logic        id;
    logic [3:0]  op;
    logic [3:0]  x;
    logic [3:0]  y;
    logic [7:0]  res;
    logic        cout;
    logic        err;
    logic [3:0]  lat;
    logic [3:0]  en_cyc;
    logic [31:0] acc_cyc;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);
  logic [EXP_W-1:0] exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_model(input logic id, input logic [3:0] op, input logic [3:0] x,
                                     input logic [3:0] y, input int acc);
    exp_t e;
    int a, b, r;
    e = '0;
    e.id = id; e.op = op; e.x = x; e.y = y; e.acc_cyc = acc;
    a = int'(x); b = int'(y); r = 0;
    if (op > 4'hA) begin
      e.err = 1'b1; e.lat = 4'd1; e.en_cyc = 4'd0;
      return e;
    end
    e.lat    = (op == 4'hA) ? 4'(1 + MC) : 4'd2;
    e.en_cyc = (op == 4'hA) ? 4'(MC) : 4'd1;
    case (op)
      4'h0: r = a & b;
      4'h1: r = ~(a & b);
      4'h2: r = a | b;
      4'h3: r = ~(a | b);
      4'h4: r = a ^ b;
      4'h5: r = ~(a ^ b);
      4'h6: r = ~a;
      4'h7: r = a * 2;
      4'h8: begin r = a + b; e.cout = (r > 15); end
      4'h9: begin r = a - b; e.cout = (a >= b); end
      default: r = a * b;
    endcase
    e.res = (op == 4'hA) ? r[7:0] : {4'b0000, r[3:0]};
    return e;
  endfunction

  // ---------------- driver state ----------------
  logic       p_valid [2];
  logic [3:0] p_op [2];
  logic [3:0] p_x [2];
  logic [3:0] p_y [2];
  logic       last_g = 1'b1;
  int         outstanding = 0;
  int         rdy_mode = 1;   // 0 low, 1 high, 2 random
  bit         rand_drop = 1'b0;
  int         grant_log[$];

  task automatic post(input int id, input logic [3:0] op, input logic [3:0] x, input logic [3:0] y);
    p_valid[id] = 1'b1; p_op[id] = op; p_x[id] = x; p_y[id] = y;
  endtask

  // One cycle: drive at the falling edge, check readys 1 time unit later.
  task automatic step();
    logic idle, v0, v1, g;
    exp_t e;
    @(negedge clk);
    if (rand_drop) begin
      for (int i = 0; i < 2; i++)
        if (p_valid[i] && ($urandom_range(0, 15) == 0)) p_valid[i] = 1'b0;
    end
    req0_valid = p_valid[0]; req0_op = p_op[0]; req0_x = p_x[0]; req0_y = p_y[0];
    req1_valid = p_valid[1]; req1_op = p_op[1]; req1_x = p_x[1]; req1_y = p_y[1];
    rsp_ready  = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
    #1;
    idle = (outstanding == 0);
    v0 = p_valid[0]; v1 = p_valid[1];
    g  = (v0 && v1) ? ~last_g : v1;
    check("req0_ready", req0_ready, idle && v0 && !g);
    check("req1_ready", req1_ready, idle && v1 && g);
    if (idle && (v0 || v1)) begin
      grant_log.push_back(req1_ready ? 1 : (req0_ready ? 0 : 2));
      last_g = g;
      e = ref_model(g, p_op[g], p_x[g], p_y[g], cyc);
      exp_q.push_back(e);
      outstanding++;
      p_valid[g] = 1'b0;
    end
  endtask

  task automatic run_idle(input int maxc);
    int n;
    n = 0;
    while ((p_valid[0] || p_valid[1] || outstanding > 0) && n < maxc) begin
      step();
      n++;
    end
    check("drain_done", (p_valid[0] || p_valid[1] || outstanding > 0), 0);
  endtask

  task automatic check_reset_outputs();
    check("reset_ready", {req0_ready, req1_ready}, 0);
    check("reset_alu", {alu_en, alu_op, alu_x, alu_y, alu_cin}, 0);
    check("reset_rsp", {rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_err}, 0);
  endtask

  // ---------------- monitor ----------------
  int en_cnt = 0;
  int wait_cnt = 0;
  bit rsp_seen = 1'b0;

  task automatic mon();
    exp_t f;
    if (alu_en) begin
      en_cnt++;
      if (exp_q.size() == 0) check("alu_en_unexpected", 1, 0);
      else begin
        f = exp_q[0];
        check("alu_op", alu_op, f.op);
        check("alu_x", alu_x, f.x);
        check("alu_y", alu_y, f.y);
        check("alu_cin", alu_cin, f.op == 4'h9);
      end
    end
    if (rsp_valid) begin
      wait_cnt = 0;
      if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
      else begin
        f = exp_q[0];
        if (!rsp_seen) begin
          rsp_seen = 1'b1;
          check("latency", cyc - int'(f.acc_cyc), f.lat);
          check("alu_en_cycles", en_cnt, f.en_cyc);
        end
        check("rsp_id", rsp_id, f.id);
        check("rsp_result", rsp_result, f.res);
        check("rsp_cout", rsp_cout, f.cout);
        check("rsp_err", rsp_err, f.err);
        if (rsp_ready) begin
          void'(exp_q.pop_front());
          outstanding--;
          rsp_seen = 1'b0;
          en_cnt = 0;
        end
      end
    end else if (outstanding > 0) begin
      wait_cnt++;
      if (wait_cnt > 30) begin
        check("rsp_timeout", 1, 0);
        wait_cnt = 0;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) mon();
    end
  end

  // Reset pulse; with now=1 it lands in the current cycle (called just
  // after a step), otherwise in the next one.
  task automatic pulse_reset(input bit now);
    if (now) #2;
    else begin @(negedge clk); #3; end
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    outstanding = 0; en_cnt = 0; wait_cnt = 0; rsp_seen = 1'b0;
    last_g = 1'b1;
    p_valid[0] = 1'b0; p_valid[1] = 1'b0;
    @(negedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int guard, seen;
    p_valid[0] = 1'b0; p_valid[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin p_op[i] = 4'h0; p_x[i] = 4'h0; p_y[i] = 4'h0; end

    // Reset held with both requesters valid: everything must stay zero.
    req0_valid = 1'b1; req1_valid = 1'b1; req0_op = 4'h8; req1_op = 4'h2;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    #3;
    rst_n = 1'b1;

    // Directed transactions.
    rdy_mode = 1;
    post(0, 4'h0, 4'b1101, 4'b1110); run_idle(20);
    post(1, 4'h8, 4'b1101, 4'b1110); run_idle(20);
    post(0, 4'h9, 4'b1001, 4'b0101); run_idle(20);
    post(0, 4'hA, 4'b1101, 4'b1110); run_idle(20);

    // Both requesters continuously valid after reset.
    pulse_reset(1'b0);
    grant_log.delete();
    guard = 0;
    while (grant_log.size() < 4 && guard < 40) begin
      if (!p_valid[0]) post(0, 4'h2, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if (!p_valid[1]) post(1, 4'h3, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      step();
      guard++;
    end
    p_valid[0] = 1'b0; p_valid[1] = 1'b0;
    run_idle(20);
    check("grant_count", grant_log.size(), 4);
    for (int k = 0; k < grant_log.size() && k < 4; k++) check("grant_order", grant_log[k], k % 2);
    post(1, 4'hC, 4'h5, 4'h6); run_idle(20);

    // Response back-pressure with requests waiting.
    post(0, 4'h4, 4'h9, 4'h3);
    rdy_mode = 0;
    step(); step();
    post(1, 4'h5, 4'h2, 4'h7);
    post(0, 4'h6, 4'hB, 4'h0);
    for (int k = 0; k < 6; k++) step();
    check("stall_rsp_valid", rsp_valid, 1);
    rdy_mode = 1;
    run_idle(40);

    // Reset during the WAIT cycle of a mult, then normal service.
    post(0, 4'hA, 4'hF, 4'hF);
    seen = 0; guard = 0;
    while (seen < MC && guard < 20) begin
      step();
      if (alu_en) seen++;
      guard++;
    end
    check("mult_reached_wait", seen, MC);
    pulse_reset(1'b1);
    step(); step();
    check("no_rsp_after_abort", rsp_valid, 0);
    post(1, 4'h8, 4'h3, 4'h4); run_idle(20);

    // Randomized traffic.
    rdy_mode = 2;
    rand_drop = 1'b1;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++)
        if (!p_valid[i] && ($urandom_range(0, 2) == 0))
          post(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      step();
    end
    rand_drop = 1'b0;
    rdy_mode = 1;
    run_idle(100);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
